// File: rtl/shift_serializer.sv
// Parallel-to-serial shifter with valid/ready load and stallable shift_en consume.
// Optional even-parity trailer bit enabled by defining SERIALIZE_PARITY_EN.
module shift_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_valid,
  input  logic [WIDTH-1:0]             load_data,
  output logic                         load_ready,
  input  logic                         shift_en,
  output logic                         serial_out,
  output logic                         serial_valid,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SERIALIZE_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;
  logic             load_ready_q, load_ready_d;
  logic             serial_valid_q, serial_valid_d;
  logic             serial_out_q, serial_out_d;
  logic             done_q, done_d;
  logic             head_bit;
`ifdef SERIALIZE_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign head_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

  // Next-state, datapath and next-output logic; outputs are registered from next state.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    done_d      = 1'b0;
`ifdef SERIALIZE_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          shreg_d     = load_data;
          bit_count_d = '0;
          state_d     = SHIFT;
`ifdef SERIALIZE_PARITY_EN
          parity_d    = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shreg_d     = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          bit_count_d = bit_count_q + CW'(1);
`ifdef SERIALIZE_PARITY_EN
          parity_d    = parity_q ^ head_bit;
          if (bit_count_q == CW'(WIDTH - 1)) state_d = PARITY;
`else
          if (bit_count_q == CW'(WIDTH - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef SERIALIZE_PARITY_EN
      PARITY: begin
        if (shift_en) begin
          bit_count_d = bit_count_q + CW'(1);
          state_d     = IDLE;
          done_d      = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    load_ready_d   = (state_d == IDLE);
    serial_valid_d = (state_d != IDLE);
    serial_out_d   = 1'b0;
    if (state_d == SHIFT) serial_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
`ifdef SERIALIZE_PARITY_EN
    if (state_d == PARITY) serial_out_d = parity_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      shreg_q        <= '0;
      bit_count_q    <= '0;
      load_ready_q   <= 1'b1;
      serial_valid_q <= 1'b0;
      serial_out_q   <= 1'b0;
      done_q         <= 1'b0;
`ifdef SERIALIZE_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      bit_count_q    <= bit_count_d;
      load_ready_q   <= load_ready_d;
      serial_valid_q <= serial_valid_d;
      serial_out_q   <= serial_out_d;
      done_q         <= done_d;
`ifdef SERIALIZE_PARITY_EN
      parity_q       <= parity_d;
`endif
    end
  end

  assign load_ready   = load_ready_q;
  assign serial_valid = serial_valid_q;
  assign serial_out   = serial_out_q;
  assign bit_count    = bit_count_q;
  assign done         = done_q;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench: MSB-first and LSB-first instances driven by shared stimulus.
module tb_shift_serializer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CW    = 3;
`ifdef SERIALIZE_PARITY_EN
  localparam int unsigned FL = WIDTH + 1;
`else
  localparam int unsigned FL = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             shift_en;
  logic             m_ready, m_out, m_valid, m_done;
  logic [CW-1:0]    m_cnt;
  logic             l_ready, l_out, l_valid, l_done;
  logic [CW-1:0]    l_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(m_ready), .shift_en(shift_en), .serial_out(m_out),
    .serial_valid(m_valid), .bit_count(m_cnt), .done(m_done)
  );

  shift_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(l_ready), .shift_en(shift_en), .serial_out(l_out),
    .serial_valid(l_valid), .bit_count(l_cnt), .done(l_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks one frame of w with shift_en=1, starting in the first-bit cycle, ending in the done cycle.
  task automatic expect_frame(input logic [WIDTH-1:0] w, input string tag);
    logic p;
    p = ^w;
    for (int i = 0; i < int'(WIDTH); i++) begin
      check({tag, "_msb_bit"}, 32'(m_out), 32'(w[WIDTH-1-i]));
      check({tag, "_lsb_bit"}, 32'(l_out), 32'(w[i]));
      check({tag, "_cnt"}, 32'(m_cnt), 32'(i));
      check({tag, "_valid"}, 32'(m_valid), 32'(1));
      check({tag, "_ready"}, 32'(m_ready), 32'(0));
      check({tag, "_nodone"}, 32'(m_done), 32'(0));
      step();
    end
`ifdef SERIALIZE_PARITY_EN
    check({tag, "_msb_par"}, 32'(m_out), 32'(p));
    check({tag, "_lsb_par"}, 32'(l_out), 32'(p));
    check({tag, "_par_valid"}, 32'(m_valid), 32'(1));
    check({tag, "_par_cnt"}, 32'(m_cnt), 32'(WIDTH));
    step();
`endif
    check({tag, "_done"}, 32'(m_done), 32'(1));
    check({tag, "_lsb_done"}, 32'(l_done), 32'(1));
    check({tag, "_end_cnt"}, 32'(m_cnt), 32'(FL));
    check({tag, "_end_ready"}, 32'(m_ready), 32'(1));
    check({tag, "_end_valid"}, 32'(m_valid), 32'(0));
    check({tag, "_end_out"}, 32'(m_out), 32'(0));
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; shift_en = 1'b0;
    step(); step();
    check("rst_ready", 32'(m_ready), 32'(1));
    check("rst_valid", 32'(m_valid), 32'(0));
    check("rst_out", 32'(m_out), 32'(0));
    check("rst_done", 32'(m_done), 32'(0));
    check("rst_cnt", 32'(m_cnt), 32'(0));
    rst_n = 1'b1;
    step();
    check("idle_hold_ready", 32'(m_ready), 32'(1));

    // Basic frame 1011 with shift_en held high
    load_valid = 1'b1; load_data = 4'b1011; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    expect_frame(4'b1011, "f1011");
    step();
    check("post_done_clear", 32'(m_done), 32'(0));
    check("idle_cnt_hold", 32'(m_cnt), 32'(FL));
    check("idle_shift_ignored", 32'(m_valid), 32'(0));

    // Stall of 3 cycles after the second bit of 1100
    w = 4'b1100;
    load_valid = 1'b1; load_data = w; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i == 2) begin
        shift_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check("stall_msb_out", 32'(m_out), 32'(w[WIDTH-1-2]));
          check("stall_lsb_out", 32'(l_out), 32'(w[2]));
          check("stall_cnt", 32'(m_cnt), 32'(2));
          check("stall_valid", 32'(m_valid), 32'(1));
        end
        shift_en = 1'b1;
      end
      check("stall_frame_msb", 32'(m_out), 32'(w[WIDTH-1-i]));
      check("stall_frame_cnt", 32'(m_cnt), 32'(i));
      step();
    end
`ifdef SERIALIZE_PARITY_EN
    check("stall_par", 32'(m_out), 32'(^w));
    step();
`endif
    check("stall_done", 32'(m_done), 32'(1));
    check("stall_end_cnt", 32'(m_cnt), 32'(FL));

    // Back-to-back: 0110 then 1001 with load_valid held
    step();
    load_valid = 1'b1; load_data = 4'b0110; shift_en = 1'b1;
    step();
    load_data = 4'b1001;
    expect_frame(4'b0110, "b2b_a");
    step();
    load_valid = 1'b0;
    expect_frame(4'b1001, "b2b_b");
    step();
    check("b2b_idle_done", 32'(m_done), 32'(0));

    // Reset mid-frame after two bits of 1111, with load_valid asserted during reset
    load_valid = 1'b1; load_data = 4'b1111; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    step(); step();
    check("pre_rst_cnt", 32'(m_cnt), 32'(2));
    rst_n = 1'b0; load_valid = 1'b1;
    step();
    rst_n = 1'b1; load_valid = 1'b0;
    check("midrst_valid", 32'(m_valid), 32'(0));
    check("midrst_cnt", 32'(m_cnt), 32'(0));
    check("midrst_ready", 32'(m_ready), 32'(1));
    check("midrst_done", 32'(m_done), 32'(0));
    check("midrst_out", 32'(m_out), 32'(0));
    step();
    check("midrst_nodone", 32'(m_done), 32'(0));
    check("midrst_idle", 32'(m_valid), 32'(0));

    // Parity-checked frame 0111
    load_valid = 1'b1; load_data = 4'b0111; shift_en = 1'b1;
    step();
    load_valid = 1'b0;
    expect_frame(4'b0111, "f0111");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
